// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_feed front end: FSM states, header bit
// positions and operand widths.
package pipe_pkg;

  localparam int unsigned OPW  = 8;   // A/B operand and stream byte width
  localparam int unsigned ACCW = 16;  // C operand / accumulator width

  localparam int unsigned HDR_AFMT_BIT    = 0;
  localparam int unsigned HDR_BFMT_BIT    = 1;
  localparam int unsigned HDR_SAVE_BIT    = 2;
  localparam int unsigned HDR_USE_ACC_BIT = 3;

  typedef enum logic [2:0] {
    HDR,
    LDA,
    LDB,
    LDC_LO,
    LDC_HI,
    FIRE,
    RD_LO,
    RD_HI
  } state_e;

  // States in which a frame is partly loaded and the idle timer runs
  function automatic logic is_loading(state_e s);
    return (s == LDA) || (s == LDB) || (s == LDC_LO) || (s == LDC_HI);
  endfunction

endpackage

// File: rtl/pipe_feed_timeout.sv
// Idle counter for pipe_feed: counts ticks since the last accepted byte and
// flags expiry on the tick that brings the count up to IDLE_TIMEOUT.
// IDLE_TIMEOUT = 0 disables expiry entirely.
module pipe_feed_timeout #(
  parameter int unsigned IDLE_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int unsigned LIM = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
  localparam logic [CW-1:0] LIMIT = LIM[CW-1:0];
  localparam logic ENABLED = (IDLE_TIMEOUT != 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the tick that would make the count equal IDLE_TIMEOUT
  assign expired = ENABLED && tick && (cnt_q == LIMIT);

  // Next count: clear on accepted byte or expiry, otherwise advance on tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (tick && ENABLED) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_feed.sv
// pipe_feed: byte-stream front end for the FP8 MAC chain (pipe0..pipe3).
// Assembles header/A/B[/C] into operand registers, fires one op cycle,
// captures the chain result into a 16-bit accumulator.
// Optional readback of the accumulator after each op: PIPE_FEED_READBACK_EN.
module pipe_feed
  import pipe_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [OPW-1:0]   in_data,
  output logic             in_ready,
  output logic [OPW-1:0]   pipe_a,
  output logic [OPW-1:0]   pipe_b,
  output logic [ACCW-1:0]  pipe_c,
  output logic             pipe_afmt,
  output logic             pipe_bfmt,
  output logic             pipe_save,
  output logic             op_valid,
  input  logic [ACCW-1:0]  res,
  input  logic             res_save,
  output logic             out_valid,
  output logic [OPW-1:0]   out_data
);

  state_e            state_q, state_d;
  logic              afmt_q, afmt_d;
  logic              bfmt_q, bfmt_d;
  logic              save_q, save_d;
  logic              use_acc_q, use_acc_d;
  logic [OPW-1:0]    a_q, a_d;
  logic [OPW-1:0]    b_q, b_d;
  logic [ACCW-1:0]   c_q, c_d;
  logic [ACCW-1:0]   acc_q, acc_d;

  logic accept;
  logic tick;
  logic expired;

  assign in_ready = (state_q == HDR) || is_loading(state_q);
  assign accept   = ena && in_valid && in_ready;
  assign tick     = ena && !in_valid && is_loading(state_q);

  pipe_feed_timeout #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .tick    (tick),
    .expired (expired)
  );

  assign op_valid  = (state_q == FIRE);
  assign pipe_a    = a_q;
  assign pipe_b    = b_q;
  assign pipe_c    = use_acc_q ? acc_q : c_q;
  assign pipe_afmt = afmt_q;
  assign pipe_bfmt = bfmt_q;
  assign pipe_save = save_q;

`ifdef PIPE_FEED_READBACK_EN
  assign out_valid = (state_q == RD_LO) || (state_q == RD_HI);
  assign out_data  = (state_q == RD_LO) ? acc_q[OPW-1:0] :
                     (state_q == RD_HI) ? acc_q[ACCW-1:OPW] : '0;
`else
  assign out_valid = 1'b0;
  assign out_data  = '0;
`endif

  // Next-state and register-load logic; nothing moves while ena is low
  always_comb begin
    state_d   = state_q;
    afmt_d    = afmt_q;
    bfmt_d    = bfmt_q;
    save_d    = save_q;
    use_acc_d = use_acc_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    acc_d     = acc_q;
    if (ena) begin
      case (state_q)
        HDR: if (accept) begin
          afmt_d    = in_data[HDR_AFMT_BIT];
          bfmt_d    = in_data[HDR_BFMT_BIT];
          save_d    = in_data[HDR_SAVE_BIT];
          use_acc_d = in_data[HDR_USE_ACC_BIT];
          state_d   = LDA;
        end
        LDA: if (accept) begin
          a_d     = in_data;
          state_d = LDB;
        end
        LDB: if (accept) begin
          b_d     = in_data;
          state_d = use_acc_q ? FIRE : LDC_LO;
        end
        LDC_LO: if (accept) begin
          c_d[OPW-1:0] = in_data;
          state_d      = LDC_HI;
        end
        LDC_HI: if (accept) begin
          c_d[ACCW-1:OPW] = in_data;
          state_d         = FIRE;
        end
        FIRE: begin
          if (res_save) begin
            acc_d = res;
          end
`ifdef PIPE_FEED_READBACK_EN
          state_d = RD_LO;
`else
          state_d = HDR;
`endif
        end
        RD_LO:   state_d = RD_HI;
        RD_HI:   state_d = HDR;
        default: state_d = HDR;
      endcase
      // expired implies no byte this cycle, so it never races an accept
      if (expired) begin
        state_d = HDR;
      end
    end
  end

  // State, operand and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HDR;
      afmt_q    <= 1'b0;
      bfmt_q    <= 1'b0;
      save_q    <= 1'b0;
      use_acc_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      afmt_q    <= afmt_d;
      bfmt_q    <= bfmt_d;
      save_q    <= save_d;
      use_acc_q <= use_acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_pipe_feed.sv
// Self-checking bench for pipe_feed. A transaction-level model (queue of
// expected ops, model accumulator, pending readback count) is checked on
// every falling edge; directed frames add hand-computed literal checks.
// Readback checks are compiled in with PIPE_FEED_READBACK_EN.
module tb_pipe_feed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  pipe_a, pipe_b;
  logic [15:0] pipe_c;
  logic        pipe_afmt, pipe_bfmt, pipe_save;
  logic        op_valid;
  logic [15:0] res;
  logic        res_save;
  logic        out_valid;
  logic [7:0]  out_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic        use_acc;
    logic        afmt;
    logic        bfmt;
    logic        save;
  } op_t;

  op_t         opq[$];
  logic [15:0] acc_m = '0;
  int          rd_pending = 0;
  logic [7:0]  rb_log[$];

  logic [7:0]  lo_a, lo_b;
  logic [15:0] lo_c;
  logic        lo_afmt, lo_bfmt, lo_save;

  pipe_feed #(.IDLE_TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pipe_a    (pipe_a),
    .pipe_b    (pipe_b),
    .pipe_c    (pipe_c),
    .pipe_afmt (pipe_afmt),
    .pipe_bfmt (pipe_bfmt),
    .pipe_save (pipe_save),
    .op_valid  (op_valid),
    .res       (res),
    .res_save  (res_save),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model and compare: evaluated mid-cycle; model state advances as the
  // following rising edge will (only when ena is high).
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_m      = '0;
      rd_pending = 0;
      opq.delete();
    end else begin
      chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !(op_valid || out_valid)});
`ifdef PIPE_FEED_READBACK_EN
      if (out_valid) begin
        if (rd_pending == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          chk("rb_byte", {24'b0, out_data},
              {24'b0, (rd_pending == 2) ? acc_m[7:0] : acc_m[15:8]});
          if (ena) begin
            rb_log.push_back(out_data);
            rd_pending--;
          end
        end
      end else if (rd_pending != 0) begin
        chk("missing_readback", 32'd0, 32'd1);
      end
`else
      chk("out_valid_tied", {31'b0, out_valid}, 32'd0);
      chk("out_data_tied", {24'b0, out_data}, 32'd0);
`endif
      if (op_valid) begin
        if (opq.size() == 0) begin
          chk("spurious_op_valid", 32'd1, 32'd0);
        end else begin
          chk("op_a", {24'b0, pipe_a}, {24'b0, opq[0].a});
          chk("op_b", {24'b0, pipe_b}, {24'b0, opq[0].b});
          chk("op_c", {16'b0, pipe_c}, {16'b0, opq[0].use_acc ? acc_m : opq[0].c});
          chk("op_fmt_save", {29'b0, pipe_afmt, pipe_bfmt, pipe_save},
              {29'b0, opq[0].afmt, opq[0].bfmt, opq[0].save});
          lo_a = pipe_a; lo_b = pipe_b; lo_c = pipe_c;
          lo_afmt = pipe_afmt; lo_bfmt = pipe_bfmt; lo_save = pipe_save;
          if (ena) begin
            if (res_save) acc_m = res;
            void'(opq.pop_front());
`ifdef PIPE_FEED_READBACK_EN
            rd_pending = 2;
`endif
          end
        end
      end
    end
  end

  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic put(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 16) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("ready_wait_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic op_t mk_op(logic [7:0] hdr, logic [7:0] a, logic [7:0] b, logic [15:0] c);
    op_t o;
    o.a = a; o.b = b; o.c = c;
    o.afmt = hdr[0]; o.bfmt = hdr[1]; o.save = hdr[2]; o.use_acc = hdr[3];
    return o;
  endfunction

  // Full frame; returns one cycle after FIRE ended (with ena high)
  task automatic frame(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] c);
    put(hdr);
    put(a);
    if (hdr[3]) begin
      opq.push_back(mk_op(hdr, a, b, c));
      put(b);
    end else begin
      put(b);
      put(c[7:0]);
      opq.push_back(mk_op(hdr, a, b, c));
      put(c[15:8]);
    end
    chk("op_latency", {31'b0, op_valid}, 32'd1);
    @(posedge clk); #1;
    chk("op_one_cycle", {31'b0, op_valid}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_rb(input string name, input logic [7:0] lo, input logic [7:0] hi);
`ifdef PIPE_FEED_READBACK_EN
    idle(2);
    if (rb_log.size() != 2) begin
      chk({name, "_count"}, rb_log.size(), 32'd2);
    end else begin
      chk({name, "_lo"}, {24'b0, rb_log[0]}, {24'b0, lo});
      chk({name, "_hi"}, {24'b0, rb_log[1]}, {24'b0, hi});
    end
    rb_log.delete();
`endif
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pipe_ab"}, {16'b0, pipe_a, pipe_b}, 32'd0);
    chk({name, "_pipe_c"}, {16'b0, pipe_c}, 32'd0);
    chk({name, "_flags"}, {28'b0, pipe_afmt, pipe_bfmt, pipe_save, op_valid}, 32'd0);
    chk({name, "_out"}, {23'b0, out_valid, out_data}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = '0;
    res = '0; res_save = 1'b0;
    #2;
    chk_all_zero("reset_init");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Full frame with loaded C
    res = 16'h3F80; res_save = 1'b1;
    frame(8'h04, 8'h38, 8'h38, 16'h0000);
    chk("f1_ops", {lo_a, lo_b, lo_c}, 32'h3838_0000);
    chk("f1_save", {31'b0, lo_save}, 32'd1);
    chk_rb("f1_rb", 8'h80, 8'h3F);

    // Accumulate with res_save=0: accumulator keeps 0x3F80
    res = 16'h1234; res_save = 1'b0;
    frame(8'h0B, 8'h3C, 8'h3C, 16'hDEAD);
    chk("f2_c_acc", {16'b0, lo_c}, 32'h3F80);
    chk("f2_fmt", {30'b0, lo_afmt, lo_bfmt}, 32'd3);
    chk_rb("f2_rb", 8'h80, 8'h3F);

    // Accumulate again, now saving
    res = 16'h4000; res_save = 1'b1;
    frame(8'h0B, 8'h3C, 8'h3C, 16'h0000);
    chk("f3_c_acc", {16'b0, lo_c}, 32'h3F80);
    chk_rb("f3_rb", 8'h00, 8'h40);

    // 14 idle cycles mid-frame: just under the timeout, frame completes
    res = 16'h1111;
    put(8'h00);
    put(8'h11);
    idle(14);
    put(8'h22);
    put(8'h33);
    opq.push_back(mk_op(8'h00, 8'h11, 8'h22, 16'h4433));
    put(8'h44);
    chk("t14_latency", {31'b0, op_valid}, 32'd1);
    idle(1);
    chk("t14_c", {16'b0, lo_c}, 32'h4433);
    chk_rb("t14_rb", 8'h11, 8'h11);

    // 15 idle cycles: aborted, back to header, no op
    put(8'h07);
    put(8'h55);
    idle(15);
    chk("t15_ready", {31'b0, in_ready}, 32'd1);
    chk("t15_no_op", {31'b0, op_valid}, 32'd0);
    res = 16'hA55A;
    frame(8'h01, 8'h66, 8'h77, 16'h9988);
    chk("t15_next", {lo_a, lo_b, lo_c}, 32'h6677_9988);
    chk("t15_afmt", {31'b0, lo_afmt}, 32'd1);
    chk_rb("t15_rb", 8'h5A, 8'hA5);

    // ena low during FIRE: pulse stretched, accumulator frozen
    put(8'h0C);
    put(8'h01);
    opq.push_back(mk_op(8'h0C, 8'h01, 8'h02, 16'h0000));
    put(8'h02);
    chk("fire_enter", {31'b0, op_valid}, 32'd1);
    ena = 1'b0;
    res = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fire_stretch", {31'b0, op_valid}, 32'd1);
    end
    chk("fire_c_acc", {16'b0, pipe_c}, 32'hA55A);
    res = 16'h7E81;
    ena = 1'b1;
    @(posedge clk); #1;
    chk("fire_end", {31'b0, op_valid}, 32'd0);
    chk_rb("fire_rb", 8'h81, 8'h7E);

`ifdef PIPE_FEED_READBACK_EN
    // ena low during RD_LO: low byte held three cycles, then high byte
    res = 16'hC33C;
    frame(8'h04, 8'h10, 8'h20, 16'h0030);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rdlo_hold", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h3C});
    end
    ena = 1'b1;
    @(posedge clk); #1;
    chk("rdhi_after", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'hC3});
    idle(1);
    rb_log.delete();
`endif

    // Asynchronous reset while in LDB
    res = 16'h5555;
    put(8'h0F);
    put(8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset2", {31'b0, in_ready}, 32'd1);
    frame(8'h08, 8'h01, 8'h02, 16'h0000);
    chk("post_reset_c", {16'b0, lo_c}, 32'h0000);
    chk_rb("post_reset_rb", 8'h55, 8'h55);

    idle(5);
    chk("all_ops_fired", opq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_feed.md
# pipe_feed

Sequential front end for the combinational FP8 multiply-accumulate chain (pipe0 → pipe3). It assembles one operation from a byte-wide input stream (header, A, B and optionally C) and presents the registered operands to pipe0 for one cycle. It captures the pipe3 result into a 16-bit accumulator, which can either feed C of the next operation or be read back as two bytes.

## Interface
Parameters:
- IDLE_TIMEOUT, 15: maximum number of consecutive cycles without `in_valid` while a frame is partly loaded before the frame is aborted; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; while low, all state, counters and the accumulator hold their values.
- in_valid  in  1  `in_data` carries a byte this cycle.
- in_data  in  8  input byte stream.
- in_ready  out  1  block can accept a byte this cycle.
- pipe_a  out  8  A operand to pipe0.
- pipe_b  out  8  B operand to pipe0.
- pipe_c  out  16  C operand to pipe0.
- pipe_afmt  out  1  A FP8 format select.
- pipe_bfmt  out  1  B FP8 format select.
- pipe_save  out  1  save flag to pipe0.
- op_valid  out  1  operands are valid and the chain result is sampled this cycle.
- res  in  16  result from pipe3.
- res_save  in  1  save flag from pipe3.
- out_valid  out  1  `out_data` carries a readback byte.
- out_data  out  8  readback byte.

## Operation
- FSM states: HDR, LDA, LDB, LDC_LO, LDC_HI, FIRE, RD_LO, RD_HI.
- A byte is accepted on a rising edge when `ena && in_valid && in_ready`.
- `in_ready` is 1 in HDR, LDA, LDB, LDC_LO and LDC_HI; it is 0 otherwise.
- Header byte fields:
  - bit0: afmt
  - bit1: bfmt
  - bit2: save
  - bit3: use_acc
  - bits 7:4: ignored
- Transitions:
  - HDR → LDA → LDB.
  - From LDB: go to FIRE if use_acc, else to LDC_LO.
  - LDC_LO loads C[7:0], then LDC_HI loads C[15:8], then → FIRE.
- use_acc=1: `pipe_c` is driven from the accumulator, and the C bytes are not requested.
- FIRE lasts exactly one cycle with `op_valid`=1.
  - At the end of FIRE, the accumulator loads `res` when `res_save`=1; otherwise it holds.
- After FIRE, go to RD_LO.
  - RD_LO: `out_valid`=1, `out_data` = acc[7:0].
  - RD_HI: `out_valid`=1, `out_data` = acc[15:8].
  - Then → HDR.
- Readback has no backpressure.
- Operand registers hold their values between operations. The `pipe_*` outputs are always driven from these registers, but they are only meaningful while `op_valid`=1.
- Timeout:
  - An idle counter increments each enabled cycle in LDA..LDC_HI with `in_valid`=0, and clears on any accepted byte.
  - When the counter reaches IDLE_TIMEOUT, the FSM returns to HDR and the counter clears.
  - Operand registers are not cleared on timeout, and there is no FIRE.
- Reset, including mid-frame:
  - State = HDR.
  - All operand registers, the accumulator and the counter = 0.
  - `op_valid` = `out_valid` = 0; `out_data` = 0.
  - `in_ready` = 1 once `rst_n` is high.

## Timing
- Latency from the last operand byte accepted to the `op_valid` pulse: 1 cycle.
- Frame length, header byte accepted to FIRE:
  - 5 cycles with C loaded.
  - 3 cycles with use_acc.
  - Both assume back-to-back bytes.
- `res` / `res_save` are sampled combinationally from the chain on the same edge that ends FIRE.
- `out_valid` is asserted for 2 consecutive cycles, immediately after FIRE. The next header can be accepted in the cycle after RD_HI.
- `ena`=0 during FIRE or RD_*: the state is held, so the pulse is stretched until `ena` returns. The accumulator does not update while `ena`=0.

## Configuration
- PIPE_FEED_READBACK_EN
  - Defined: RD_LO and RD_HI exist, as described above.
  - Undefined: FIRE → HDR directly; `out_valid` and `out_data` are tied to 0; the accumulator is still updated and `use_acc` still works.

## Structure
- Shared package `pipe_pkg`:
  - FSM state enum.
  - Header bit-position constants.
  - Operand width constants: 8, 16.
- One natural sub-module, `pipe_feed_timeout`: the idle counter, with `clear` / `tick` inputs and an `expired` output.

## Test plan
- Full frame: header 0x04, A=0x38, B=0x38, C=0x00, 0x00; stub `res`=0x3F80, `res_save`=1.
  - `op_valid` one cycle with `pipe_a`=0x38, `pipe_b`=0x38, `pipe_c`=0x0000, `pipe_save`=1.
  - Readback 0x80 then 0x3F.
- Accumulate: after the previous frame, header 0x0B, A=0x3C, B=0x3C.
  - FIRE after 3 bytes, with `pipe_c`=0x3F80, `pipe_afmt`=1, `pipe_bfmt`=1.
- `res_save`=0 in FIRE with `res`=0x1234: the accumulator keeps 0x3F80, and the readback is 0x80, 0x3F.
- Timeout (IDLE_TIMEOUT=15): header, A, then 15 idle cycles.
  - Back in HDR; no `op_valid`; `in_ready`=1.
  - The next full frame works normally.
- Reset: assert `rst_n` low mid-LDB (asynchronously).
  - All outputs are 0 immediately; the accumulator is 0.
  - A use_acc frame then shows `pipe_c`=0x0000.
- `ena` gating: hold `ena` low for 3 cycles during RD_LO; `out_data`=acc[7:0] is held for those 3 cycles, then RD_HI follows.
